psum_drain_ctrl: RTL and testbench

- Reader side of the partial-sum accumulation buffer. Once accumulation completes, it walks the psum memory group by group and streams each 32-bit word (four packed 8-bit kernel psums) out on a valid/ready interface toward the output writeback path.
- Optionally writes zero behind each read (clear-on-read), so the buffer is clean for the next layer.
- Absorbs fixed memory read latency and downstream backpressure with a credit-controlled FIFO.

---
 rtl/psum_drain_pkg.sv | 16 +
 rtl/psum_drain_fifo.sv | 48 ++++
 rtl/psum_drain_ctrl.sv | 177 +++++++++++++++++
 tb/tb_psum_drain_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: shared FSM encoding and config field positions
// for the partial-sum drain path.
package psum_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_FLUSH,
    ST_DONE
  } drain_st_t;

  localparam int CONF_CLR_BIT   = 5;
  localparam int KSHAPE_KCNT_HI = 31;
  localparam int KSHAPE_KCNT_LO = 16;

endpackage

// File: rtl/psum_drain_fifo.sv
// psum_drain_fifo: synchronous FIFO absorbing read latency and
// downstream stalls; push and pop may coincide even when full.
module psum_drain_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/psum_drain_ctrl.sv
// psum_drain_ctrl: walks the psum buffer group by group, streams
// each word out, and optionally zeroes it behind the read.
module psum_drain_ctrl
  import psum_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int MEM_DELAY  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_KERNEL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
  input  logic [REG_WIDTH-1:0]  i_conf_kernelshape,
  output logic [ADDR_WIDTH-1:0] memctrl_radd,
  output logic                  memctrl_rden,
  input  logic [DATA_WIDTH-1:0] memctrl_odat,
  input  logic                  memctrl_ovld,
  output logic [ADDR_WIDTH-1:0] memctrl_wadd,
  output logic                  memctrl_wren,
  output logic [DATA_WIDTH-1:0] memctrl_idat,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_vld,
  output logic                  o_last,
  input  logic                  i_rdy,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [REG_WIDTH-1:0]  dbg_drain_rd_addr,
  output logic [REG_WIDTH-1:0]  dbg_drain_grp_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int KW = KSHAPE_KCNT_HI - KSHAPE_KCNT_LO + 1;

  drain_st_t             state;
  drain_st_t             state_d;
  logic                  clr_en;
  logic [REG_WIDTH-1:0]  wpg_m1;
  logic [REG_WIDTH-1:0]  num_grp;
  logic [REG_WIDTH-1:0]  word_idx;
  logic [REG_WIDTH-1:0]  grp_cnt;
  logic [REG_WIDTH-1:0]  grp_in;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] grp_base;
  logic [ADDR_WIDTH-1:0] grp_next;
  logic [ADDR_WIDTH-1:0] addr_sr [MEM_DELAY];
  logic [MEM_DELAY-1:0]  last_sr;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           occ;
  logic [KW-1:0]         kcnt;
  logic [DATA_WIDTH-1:0] head_dat;
  logic                  head_last;
  logic                  start_ok;
  logic                  grp_end;
  logic                  last_word;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  unused;

  assign kcnt      = i_conf_kernelshape[KSHAPE_KCNT_HI:KSHAPE_KCNT_LO];
  assign grp_in    = REG_WIDTH'(kcnt >> $clog2(NUM_KERNEL));
  assign start_ok  = i_start && (state == ST_IDLE || state == ST_DONE);
  assign grp_end   = word_idx == wpg_m1;
  assign last_word = grp_end && (grp_cnt == num_grp - REG_WIDTH'(1));
  assign grp_next  = grp_base + ADDR_WIDTH'(wpg_m1) + ADDR_WIDTH'(1);
  assign occ       = {1'b0, fifo_cnt} + {1'b0, inflight};

  // Credit covers words already buffered plus reads still in the memory pipe.
  assign memctrl_rden = (state == ST_READ) && (occ < (CW + 1)'(FIFO_DEPTH));
  assign memctrl_radd = rd_addr;
  assign memctrl_idat = '0;

  // Late read data after an abort must not land in the FIFO.
  assign push = memctrl_ovld && (state != ST_IDLE);
  assign pop  = o_vld && i_rdy;

  assign o_vld  = !fifo_empty;
  assign o_dat  = o_vld ? head_dat : '0;
  assign o_last = o_vld && head_last;
  assign o_busy = (state == ST_READ) || (state == ST_FLUSH);
  assign o_done = state == ST_DONE;

  assign dbg_drain_rd_addr = REG_WIDTH'(rd_addr);
  assign dbg_drain_grp_cnt = grp_cnt;

  assign unused = ^{i_conf_ctrl, i_conf_kernelshape[KSHAPE_KCNT_LO-1:0], fifo_full};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (i_start) state_d = (grp_in == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        if (memctrl_rden && last_word) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (inflight == '0 && fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_en       <= 1'b0;
      wpg_m1       <= '0;
      num_grp      <= '0;
      word_idx     <= '0;
      grp_cnt      <= '0;
      rd_addr      <= '0;
      grp_base     <= '0;
      inflight     <= '0;
      last_sr      <= '0;
      memctrl_wren <= 1'b0;
      memctrl_wadd <= '0;
      for (int i = 0; i < MEM_DELAY; i++) addr_sr[i] <= '0;
    end else begin
      if (start_ok) begin
        clr_en   <= i_conf_ctrl[CONF_CLR_BIT];
        wpg_m1   <= i_conf_outputsize;
        num_grp  <= grp_in;
        word_idx <= '0;
        grp_cnt  <= '0;
        rd_addr  <= '0;
        grp_base <= '0;
      end else if (memctrl_rden) begin
        if (grp_end) begin
          word_idx <= '0;
          grp_cnt  <= grp_cnt + REG_WIDTH'(1);
          grp_base <= grp_next;
          rd_addr  <= grp_next;
        end else begin
          word_idx <= word_idx + REG_WIDTH'(1);
          rd_addr  <= rd_addr + ADDR_WIDTH'(1);
        end
      end
      inflight   <= inflight + CW'(memctrl_rden) - CW'(push);
      last_sr[0] <= memctrl_rden && grp_end;
      addr_sr[0] <= rd_addr;
      for (int i = 1; i < MEM_DELAY; i++) begin
        last_sr[i] <= last_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
      end
      memctrl_wren <= push && clr_en;
      if (push) memctrl_wadd <= addr_sr[MEM_DELAY-1];
    end
  end

  psum_drain_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({memctrl_odat, last_sr[MEM_DELAY-1]}),
    .head  ({head_dat, head_last}),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// tb_psum_drain_ctrl: scoreboard bench with a fixed-latency memory
// model and a group/word reference of the expected drain stream.
`timescale 1ns/1ps
module tb_psum_drain_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 32;
  localparam int MD = 2;
  localparam int FD = 4;
  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [RW-1:0] i_conf_ctrl = '0;
  logic [RW-1:0] i_conf_outputsize = '0;
  logic [RW-1:0] i_conf_kernelshape = '0;
  logic [AW-1:0] memctrl_radd;
  logic          memctrl_rden;
  logic [DW-1:0] memctrl_odat = '0;
  logic          memctrl_ovld = 1'b0;
  logic [AW-1:0] memctrl_wadd;
  logic          memctrl_wren;
  logic [DW-1:0] memctrl_idat;
  logic [DW-1:0] o_dat;
  logic          o_vld;
  logic          o_last;
  logic          i_rdy = 1'b1;
  logic          o_busy;
  logic          o_done;
  logic [RW-1:0] dbg_a;
  logic [RW-1:0] dbg_g;

  int vecs = 0;
  int errs = 0;

  logic [DW-1:0] mem     [64];
  logic [DW-1:0] ref_mem [64];
  int            exp_addr[$];
  logic [DW:0]   exp_word[$];
  int            exp_wadd[$];

  int            occ = 0;
  int            done_rises = 0;
  int            rdy_mode = 0;
  int            cyc = 0;
  logic          prev_done = 1'b0;
  logic          cap_v = 1'b0;
  logic          q_v = 1'b0;
  logic [AW-1:0] cap_a = '0;
  logic [AW-1:0] q_a = '0;

  psum_drain_ctrl #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .REG_WIDTH (RW),
    .MEM_DELAY (MD), .FIFO_DEPTH (FD), .NUM_KERNEL (NK)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (i_start),
    .i_conf_ctrl        (i_conf_ctrl),
    .i_conf_outputsize  (i_conf_outputsize),
    .i_conf_kernelshape (i_conf_kernelshape),
    .memctrl_radd       (memctrl_radd),
    .memctrl_rden       (memctrl_rden),
    .memctrl_odat       (memctrl_odat),
    .memctrl_ovld       (memctrl_ovld),
    .memctrl_wadd       (memctrl_wadd),
    .memctrl_wren       (memctrl_wren),
    .memctrl_idat       (memctrl_idat),
    .o_dat              (o_dat),
    .o_vld              (o_vld),
    .o_last             (o_last),
    .i_rdy              (i_rdy),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .dbg_drain_rd_addr  (dbg_a),
    .dbg_drain_grp_cnt  (dbg_g)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Memory: read data returns MD cycles after rden; clears land on wren.
  always @(negedge clk) begin
    cap_v = memctrl_rden;
    cap_a = memctrl_radd;
    if (memctrl_wren) mem[memctrl_wadd[5:0]] = memctrl_idat;
  end

  always @(posedge clk) begin
    #1;
    memctrl_ovld = q_v;
    memctrl_odat = q_v ? mem[q_a[5:0]] : '0;
    q_v = cap_v;
    q_a = cap_a;
    cyc++;
    case (rdy_mode)
      0:       i_rdy = 1'b1;
      1:       i_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: i_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares every read issue, stream word and clear write.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst) begin
      occ = 0;
      exp_addr.delete();
      exp_word.delete();
      exp_wadd.delete();
      prev_done = 1'b0;
    end else begin
      if (memctrl_rden) begin
        check("rd_credit", longint'(occ < FD), 1);
        if (exp_addr.size() == 0) check("rd_unexpected", memctrl_rden, 0);
        else check("rd_addr", memctrl_radd, exp_addr.pop_front());
      end
      if (o_vld && i_rdy) begin
        if (exp_word.size() == 0) check("out_unexpected", o_vld, 0);
        else begin
          e = exp_word.pop_front();
          check("out_dat", o_dat, e[DW:1]);
          check("out_last", o_last, e[0]);
        end
      end
      occ = occ + int'(memctrl_rden) - int'(o_vld && i_rdy);
      if (memctrl_wren) begin
        if (exp_wadd.size() == 0) check("wr_unexpected", memctrl_wren, 0);
        else begin
          check("wr_addr", memctrl_wadd, exp_wadd.pop_front());
          check("wr_dat", memctrl_idat, 0);
        end
      end
      if (o_done && !prev_done) begin
        done_rises++;
        check("done_early", exp_word.size(), 0);
      end
      prev_done = o_done;
    end
  end

  task automatic expect_drain(input int osz, input int kc, input bit clr);
    int wpg;
    int ng;
    int a;
    logic lst;
    wpg = osz + 1;
    ng  = kc / NK;
    for (int g = 0; g < ng; g++) begin
      for (int w = 0; w < wpg; w++) begin
        a   = g * wpg + w;
        lst = (w == wpg - 1);
        exp_addr.push_back(a);
        exp_word.push_back({ref_mem[a], lst});
        if (clr) begin
          exp_wadd.push_back(a);
          ref_mem[a] = '0;
        end
      end
    end
  endtask

  task automatic pulse_start(input int osz, input int kc, input bit clr);
    logic [15:0] k16;
    k16 = 16'(kc);
    @(posedge clk); #1;
    i_conf_ctrl        = ($urandom & 32'hFFFF_FFDF) | (32'(clr) << 5);
    i_conf_outputsize  = RW'(osz);
    i_conf_kernelshape = {k16, 16'($urandom)};
    i_start            = 1'b1;
    done_rises         = 0;
    @(posedge clk); #1;
    i_start            = 1'b0;
    i_conf_ctrl        = $urandom;
    i_conf_outputsize  = $urandom;
    i_conf_kernelshape = $urandom;
  endtask

  task automatic drain(input int osz, input int kc, input bit clr,
                       input int mode, input bit poke);
    int n;
    rdy_mode = mode;
    expect_drain(osz, kc, clr);
    pulse_start(osz, kc, clr);
    @(negedge clk);
    if (kc / NK == 0) begin
      check("zero_done", o_done, 1);
      check("zero_busy", o_busy, 0);
    end else begin
      check("start_busy", o_busy, 1);
      check("start_done_clr", o_done, 0);
    end
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      i_start            = 1'b1;
      i_conf_outputsize  = '0;
      i_conf_kernelshape = 32'h0004_0000;
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    n = 0;
    while (!o_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", o_done, 1);
    repeat (4) @(negedge clk);
    check("done_once", done_rises, 1);
    check("busy_end", o_busy, 0);
    check("rd_left", exp_addr.size(), 0);
    check("out_left", exp_word.size(), 0);
    check("wr_left", exp_wadd.size(), 0);
  endtask

  initial begin
    int n;
    bit seen;
    int osz;
    int kc;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", o_vld, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rden", memctrl_rden, 0);
    check("rst_wren", memctrl_wren, 0);
    check("rst_radd", memctrl_radd, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    drain(3, 0, 0, 0, 0);
    drain(3, 8, 0, 0, 0);
    drain(3, 8, 0, 1, 0);

    mem[0] = 32'hA5A5_A5A5;  mem[1] = 32'hA5A5_A5A5;
    ref_mem[0] = 32'hA5A5_A5A5;  ref_mem[1] = 32'hA5A5_A5A5;
    drain(1, 4, 1, 0, 0);
    drain(1, 4, 0, 0, 0);

    // Abort one cycle after the first read; late read data must vanish.
    rdy_mode = 0;
    expect_drain(3, 8, 0);
    pulse_start(3, 8, 0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = memctrl_rden;
      n++;
    end
    check("abort_rden_seen", seen, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_vld", o_vld, 0);
      check("abort_busy", o_busy, 0);
      check("abort_done", o_done, 0);
    end
    drain(3, 8, 0, 0, 0);

    drain(3, 8, 0, 1, 1);

    for (int it = 0; it < 12; it++) begin
      osz = $urandom_range(0, 3);
      kc  = $urandom_range(4, 13);
      drain(osz, kc, 1'($urandom_range(0, 1)), 2,
            ((osz + 1) * (kc / NK) >= 8) && ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
